// File: rtl/imem_loader.sv
// imem_loader
//   Instruction-memory responder for the single-cycle RISC-V core.
//   A program is first streamed in one byte at a time and packed into 32-bit
//   words, little-endian. While it loads, the core is parked at PC 0xFFFFFFFF
//   and is fed NOPs. Once loading ends, the core runs from word 0 up to the
//   last loaded word, and then holds there.
//
// Parameters
//   DEPTH_LOG2 : memory holds 2^DEPTH_LOG2 32-bit words
//   NOP        : word returned for any unloaded or out-of-range fetch
//
// Ports
//   clk, rst_n  : clock; asynchronous active-low reset
//   instr_addr  : word address of the next fetch (the core's pc_next)
//   instr_data  : fetched word, registered (1-cycle latency)
//   last_pc     : stop bound for the core, registered
//   load_data   : program byte
//   load_valid  : load_data is valid
//   load_ready  : a byte is accepted this cycle
//   load_done   : end-of-program pulse
//   reload      : restart loading; only acted on in RUN
//   run         : high while in RUN
module imem_loader #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP        = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        load_done,
  input  logic        reload,
  output logic        run
);

  localparam int             CW       = DEPTH_LOG2 + 1;
  localparam int             DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] word_cnt, word_cnt_next;
  logic [1:0]    byte_cnt, byte_cnt_next;
  logic [31:0]   asm_word, asm_next;
  logic [31:0]   last_pc_next;
  logic          run_next;
  logic          accept;
  logic [31:0]   merged;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          fetch_hit;

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOAD;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      last_pc  <= 32'hFFFFFFFF;
      run      <= 1'b0;
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
      byte_cnt <= byte_cnt_next;
      asm_word <= asm_next;
      last_pc  <= last_pc_next;
      run      <= run_next;
    end
  end

  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    byte_cnt_next = byte_cnt;
    asm_next      = asm_word;
    last_pc_next  = last_pc;
    run_next      = run;
    load_ready    = 1'b0;
    accept        = 1'b0;
    merged        = asm_word;
    mem_we        = 1'b0;
    mem_wdata     = asm_word;

    case (state)
      ST_LOAD: begin
        load_ready = (word_cnt < FULL_CNT);
        accept     = load_valid && load_ready;
        // The incoming byte lands in lane byte_cnt; the upper lanes are still zero.
        merged     = asm_word | ({24'h0, load_data} << {byte_cnt, 3'b000});

        if (accept) begin
          if (byte_cnt == 2'd3) begin
            mem_we        = 1'b1;
            mem_wdata     = merged;
            word_cnt_next = word_cnt + CW'(1);
            byte_cnt_next = 2'd0;
            asm_next      = '0;
          end else begin
            byte_cnt_next = byte_cnt + 2'd1;
            asm_next      = merged;
          end
        end

        // After folding in any same-cycle byte, a non-zero lane count means a
        // partial word remains. It is committed as is, with its upper lanes zero.
        if (load_done && byte_cnt_next != 2'd0) begin
          mem_we        = 1'b1;
          mem_wdata     = asm_next;
          word_cnt_next = word_cnt + CW'(1);
          byte_cnt_next = 2'd0;
          asm_next      = '0;
        end

        if (load_done || word_cnt_next == FULL_CNT) begin
          state_next   = ST_RUN;
          run_next     = 1'b1;
          // An empty program wraps to 0xFFFFFFFF, so the core stays parked.
          last_pc_next = 32'(word_cnt_next) - 32'd1;
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_next    = ST_LOAD;
          run_next      = 1'b0;
          word_cnt_next = '0;
          byte_cnt_next = 2'd0;
          asm_next      = '0;
          last_pc_next  = 32'hFFFFFFFF;
        end
      end

      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // Memory contents are never cleared. Stale words stay unreadable because
  // fetches are bounded by word_cnt.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_cnt[DEPTH_LOG2-1:0]] <= mem_wdata;
    end
  end

  assign fetch_hit = (state == ST_RUN) &&
                     (instr_addr[31:DEPTH_LOG2] == '0) &&
                     (instr_addr < 32'(word_cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_data <= NOP;
    end else if (fetch_hit) begin
      instr_data <= mem[instr_addr[DEPTH_LOG2-1:0]];
    end else begin
      instr_data <= NOP;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Drives the imem_loader byte-stream load port and fetch port. It checks
//   the outputs against a word-level model built straight from the streamed
//   byte list. Uses a default-depth instance, plus a DEPTH_LOG2=2 instance
//   for the memory-full case.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic [31:0] last_pc;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        reload;
  logic        run;

  logic        b_rst_n;
  logic [31:0] b_instr_addr;
  logic [31:0] b_instr_data;
  logic [31:0] b_last_pc;
  logic [7:0]  b_load_data;
  logic        b_load_valid;
  logic        b_load_ready;
  logic        b_load_done;
  logic        b_reload;
  logic        b_run;

  int checks = 0;
  int passes = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] exp_mem [0:255];
  int          exp_words;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .last_pc    (last_pc),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .reload     (reload),
    .run        (run)
  );

  imem_loader #(.DEPTH_LOG2(2)) dut_small (
    .clk        (clk),
    .rst_n      (b_rst_n),
    .instr_addr (b_instr_addr),
    .instr_data (b_instr_data),
    .last_pc    (b_last_pc),
    .load_data  (b_load_data),
    .load_valid (b_load_valid),
    .load_ready (b_load_ready),
    .load_done  (b_load_done),
    .reload     (b_reload),
    .run        (b_run)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level model: group the byte list into little-endian words, zero-padded.
  task automatic model_build();
    exp_words = (stim_q.size() + 3) / 4;
    for (int i = 0; i < exp_words; i++) begin
      exp_mem[i] = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * i + k < stim_q.size()) exp_mem[i][8*k +: 8] = stim_q[4*i + k];
      end
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    if (a < 32'(exp_words)) return exp_mem[a[7:0]];
    return NOP;
  endfunction

  task automatic send_stream(input bit done_on_last, input int max_gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      load_data  = stim_q[i];
      load_valid = 1'b1;
      load_done  = done_on_last && (i == stim_q.size() - 1);
      tick();
      load_valid = 1'b0;
      load_done  = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_addr = 32'h0; load_data = 8'h0;
    load_valid = 1'b0; load_done = 1'b0; reload = 1'b0;
    #12;
    checks++; if (run !== 1'b0) $display("[TB] FAIL reset_run: got %b expected 0", run); else passes++;
    checks++; if (last_pc !== 32'hFFFFFFFF) $display("[TB] FAIL reset_last_pc: got %h expected ffffffff", last_pc); else passes++;
    checks++; if (instr_data !== NOP) $display("[TB] FAIL reset_instr_data: got %h expected %h", instr_data, NOP); else passes++;
    checks++; if (load_ready !== 1'b1) $display("[TB] FAIL reset_load_ready: got %b expected 1", load_ready); else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    stim_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    model_build();
    instr_addr = 32'h0;
    send_stream(1'b0, 0);
    checks++; if (instr_data !== NOP) $display("[TB] FAIL basic_nop_while_loading: got %h expected %h", instr_data, NOP); else passes++;
    checks++; if (last_pc !== 32'hFFFFFFFF) $display("[TB] FAIL basic_last_pc_loading: got %h expected ffffffff", last_pc); else passes++;
    pulse_done();
    checks++; if (run !== 1'b1) $display("[TB] FAIL basic_run: got %b expected 1", run); else passes++;
    checks++; if (last_pc !== 32'(exp_words) - 32'd1) $display("[TB] FAIL basic_last_pc: got %h expected %h", last_pc, 32'(exp_words) - 32'd1); else passes++;
    checks++; if (load_ready !== 1'b0) $display("[TB] FAIL basic_ready_in_run: got %b expected 0", load_ready); else passes++;
    for (int a = 0; a < 3; a++) begin
      instr_addr = 32'(a);
      tick();
      checks++; if (instr_data !== model_fetch(32'(a))) $display("[TB] FAIL basic_fetch%0d: got %h expected %h", a, instr_data, model_fetch(32'(a))); else passes++;
    end
  endtask

  task automatic test_reload();
    instr_addr = 32'h0;
    pulse_reload();
    checks++; if (run !== 1'b0) $display("[TB] FAIL reload_run: got %b expected 0", run); else passes++;
    checks++; if (load_ready !== 1'b1) $display("[TB] FAIL reload_ready: got %b expected 1", load_ready); else passes++;
    checks++; if (last_pc !== 32'hFFFFFFFF) $display("[TB] FAIL reload_last_pc: got %h expected ffffffff", last_pc); else passes++;
    tick();
    checks++; if (instr_data !== NOP) $display("[TB] FAIL reload_instr_nop: got %h expected %h", instr_data, NOP); else passes++;
    stim_q = '{};
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom_range(255, 0)));
    model_build();
    send_stream(1'b0, 1);
    pulse_done();
    checks++; if (last_pc !== 32'h0) $display("[TB] FAIL reload_new_last_pc: got %h expected 00000000", last_pc); else passes++;
    instr_addr = 32'h0;
    tick();
    checks++; if (instr_data !== exp_mem[0]) $display("[TB] FAIL reload_new_word: got %h expected %h", instr_data, exp_mem[0]); else passes++;
  endtask

  task automatic test_partial_done();
    pulse_reload();
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    model_build();
    send_stream(1'b1, 2);
    checks++; if (run !== 1'b1) $display("[TB] FAIL partial_run: got %b expected 1", run); else passes++;
    checks++; if (last_pc !== 32'(exp_words) - 32'd1) $display("[TB] FAIL partial_last_pc: got %h expected %h", last_pc, 32'(exp_words) - 32'd1); else passes++;
    for (int a = 0; a < 3; a++) begin
      instr_addr = 32'(a);
      tick();
      checks++; if (instr_data !== model_fetch(32'(a))) $display("[TB] FAIL partial_fetch%0d: got %h expected %h", a, instr_data, model_fetch(32'(a))); else passes++;
    end
  endtask

  task automatic test_empty_done();
    pulse_reload();
    stim_q = '{};
    model_build();
    pulse_done();
    checks++; if (run !== 1'b1) $display("[TB] FAIL empty_run: got %b expected 1", run); else passes++;
    checks++; if (last_pc !== 32'hFFFFFFFF) $display("[TB] FAIL empty_last_pc: got %h expected ffffffff", last_pc); else passes++;
    for (int a = 0; a < 2; a++) begin
      instr_addr = 32'(a);
      tick();
      checks++; if (instr_data !== NOP) $display("[TB] FAIL empty_fetch%0d: got %h expected %h", a, instr_data, NOP); else passes++;
    end
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    stim_q = '{8'hDE, 8'hAD, 8'hBE};
    send_stream(1'b0, 0);
    rst_n = 1'b0;
    #2;
    checks++; if (last_pc !== 32'hFFFFFFFF) $display("[TB] FAIL midreset_last_pc: got %h expected ffffffff", last_pc); else passes++;
    rst_n = 1'b1;
    tick();
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    model_build();
    send_stream(1'b0, 0);
    pulse_done();
    checks++; if (last_pc !== 32'h0) $display("[TB] FAIL midreset_new_last_pc: got %h expected 00000000", last_pc); else passes++;
    for (int a = 0; a < 2; a++) begin
      instr_addr = 32'(a);
      tick();
      checks++; if (instr_data !== model_fetch(32'(a))) $display("[TB] FAIL midreset_fetch%0d: got %h expected %h", a, instr_data, model_fetch(32'(a))); else passes++;
    end
  endtask

  task automatic test_mem_full();
    logic [31:0] addrs [0:5];
    b_rst_n = 1'b0; b_instr_addr = 32'h0; b_load_data = 8'h0;
    b_load_valid = 1'b0; b_load_done = 1'b0; b_reload = 1'b0;
    tick();
    b_rst_n = 1'b1;
    tick();
    stim_q = '{};
    b_load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_load_data = 8'($urandom_range(255, 0));
      stim_q.push_back(b_load_data);
      checks++; if (b_load_ready !== 1'b1) $display("[TB] FAIL full_ready_byte%0d: got %b expected 1", i, b_load_ready); else passes++;
      tick();
      if (i == 14) begin
        checks++; if (b_run !== 1'b0) $display("[TB] FAIL full_run_early: got %b expected 0", b_run); else passes++;
      end
    end
    model_build();
    checks++; if (b_load_ready !== 1'b0) $display("[TB] FAIL full_ready_drop: got %b expected 0", b_load_ready); else passes++;
    checks++; if (b_run !== 1'b1) $display("[TB] FAIL full_run: got %b expected 1", b_run); else passes++;
    checks++; if (b_last_pc !== 32'd3) $display("[TB] FAIL full_last_pc: got %h expected 00000003", b_last_pc); else passes++;
    b_load_data = 8'h5A;
    tick();
    tick();
    b_load_valid = 1'b0;
    addrs = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h100};
    for (int i = 0; i < 6; i++) begin
      b_instr_addr = addrs[i];
      tick();
      checks++; if (b_instr_data !== model_fetch(addrs[i])) $display("[TB] FAIL full_fetch_%h: got %h expected %h", addrs[i], b_instr_data, model_fetch(addrs[i])); else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          n;
    bit          done_on_last;
    for (int it = 0; it < 6; it++) begin
      pulse_reload();
      n = $urandom_range(24, 0);
      stim_q = '{};
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(255, 0)));
      model_build();
      done_on_last = (n > 0) && ($urandom_range(1, 0) == 1);
      send_stream(done_on_last, 2);
      if (!done_on_last) pulse_done();
      checks++; if (run !== 1'b1) $display("[TB] FAIL rand%0d_run: got %b expected 1", it, run); else passes++;
      checks++; if (last_pc !== 32'(exp_words) - 32'd1) $display("[TB] FAIL rand%0d_last_pc: got %h expected %h", it, last_pc, 32'(exp_words) - 32'd1); else passes++;
      for (int f = 0; f < 6; f++) begin
        if (f == 5) a = 32'h8000_0000 | 32'($urandom_range(3, 0));
        else a = 32'($urandom_range(exp_words + 2, 0));
        instr_addr = a;
        tick();
        checks++; if (instr_data !== model_fetch(a)) $display("[TB] FAIL rand%0d_fetch_%h: got %h expected %h", it, a, instr_data, model_fetch(a)); else passes++;
      end
    end
  endtask

  initial begin
    $display("[TB] starting imem_loader bench");
    test_reset();
    test_basic_load();
    test_reload();
    test_partial_done();
    test_empty_done();
    test_reset_midload();
    test_mem_full();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the single-cycle RISC-V core: it answers the core's per-cycle fetch and drives its `last_pc` stop bound. It also owns a byte-stream load port through which a program is written before execution. While a program is loading, the core is parked at PC 0xFFFFFFFF and sees NOPs. Once the load completes, the core runs from address 0 to the last loaded word and then holds there.

## Interface
- `DEPTH_LOG2`, default 8: memory holds 2^DEPTH_LOG2 32-bit words.
- `NOP`, default 32'h00000013: word returned for any unloaded or out-of-range fetch (`addi x0,x0,0`).

- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_addr` in 32: word address of the next fetch; the core's `pc_next`.
- `instr_data` out 32: fetched word, registered.
- `last_pc` out 32: stop bound for the core, registered.
- `load_data` in 8: program byte, little-endian within each word.
- `load_valid` in 1: `load_data` is valid.
- `load_ready` out 1: the block accepts a byte this cycle.
- `load_done` in 1: end-of-program marker, single-cycle pulse.
- `reload` in 1: single-cycle pulse; restart loading from RUN.
- `run` out 1: high while in RUN.

## Operation
- FSM states: LOAD and RUN. Reset enters LOAD.
- Registers and their reset values:
  - `word_cnt` (DEPTH_LOG2+1 bits) = 0
  - `byte_cnt` (2 bits) = 0
  - `asm_word` (32 bits) = 0
  - `instr_data` = NOP
  - `last_pc` = 32'hFFFFFFFF
  - `run` = 0
- Memory array contents are never cleared.
- LOAD, byte acceptance:
  - `load_ready` = 1 while `word_cnt` < 2^DEPTH_LOG2.
  - A byte is accepted on `load_valid && load_ready` and is placed in lane `byte_cnt` of `asm_word` (bits 8*byte_cnt+7:8*byte_cnt).
  - Then `byte_cnt`++.
- LOAD, word commit:
  - When the 4th byte is accepted, {byte, asm_word[23:0]} is written to `mem[word_cnt]`.
  - Then `word_cnt`++, `byte_cnt` = 0, `asm_word` = 0.
- LOAD, `load_done`:
  - If `byte_cnt` != 0, the partial word is zero-padded in its upper lanes and written, and `word_cnt`++.
  - In either case the FSM goes to RUN.
  - If a byte is accepted in the same cycle as `load_done`, that byte is included before padding and commit.
- LOAD, memory full: the cycle whose commit makes `word_cnt` = 2^DEPTH_LOG2 also goes to RUN; there is no `load_done` wait. `load_ready` is 0 whenever `word_cnt` is full.
- LOAD outputs: `last_pc` held at 32'hFFFFFFFF, so the core's PC is frozen at 0xFFFFFFFF.
- RUN:
  - `load_ready` = 0; `load_valid` and `load_done` are ignored.
  - `last_pc` = `word_cnt` − 1, zero-extended, with 32-bit wrap. An empty program gives 0xFFFFFFFF, and the core stays parked.
  - `reload` → LOAD with `word_cnt`, `byte_cnt`, `asm_word` cleared and `last_pc` = 0xFFFFFFFF.
- Fetch, every cycle:
  - `instr_data` <= `mem[instr_addr[DEPTH_LOG2-1:0]]` when state is RUN, `instr_addr[31:DEPTH_LOG2]` == 0, and `instr_addr` < `word_cnt`.
  - Otherwise `instr_data` <= NOP.
  - All conditions are evaluated on pre-edge values.
- Asynchronous reset mid-load discards any partial word and `word_cnt`; stale memory words are unreadable because `word_cnt` = 0.

## Timing
- Fetch latency is 1 cycle: the address presented before edge N yields data after edge N. This matches the core, which presents `pc_next` and consumes `instr_data` as the instruction at `pc`.
- Byte handshake: one byte per cycle maximum. `load_ready` is a combinational function of state and `word_cnt` only, never of `load_valid`.
- Word write lands at the same edge as the 4th byte.
- LOAD→RUN transition:
  - At the edge sampling `load_done` (or the full commit), `run`, `last_pc` and the state update together.
  - The first RUN fetch is evaluated at the following edge. The core's PC goes 0xFFFFFFFF → 0 one cycle after `last_pc` changes, and `instr_data` then holds `mem[0]`.
- RUN→LOAD on `reload`: `last_pc` = 0xFFFFFFFF and `instr_data` = NOP from the next edge on.

## Test plan
- Reset, then stream 8 bytes 13 05 10 00 93 05 20 00, then pulse `load_done` → `last_pc` = 1, `run` = 1. Fetch addr 0 → 32'h00100513; fetch addr 1 → 32'h00200593; fetch addr 2 → NOP.
- Stream 6 bytes AA BB CC DD 11 22 with `load_done` on the 6th byte → word1 = 32'h00002211, `last_pc` = 1.
- `load_done` with no bytes → `run` = 1, `last_pc` = 32'hFFFFFFFF, every fetch returns NOP.
- DEPTH_LOG2 = 2, stream 16 bytes with `load_valid` held high → `load_ready` drops after the 16th byte, `run` = 1 with no `load_done`, `last_pc` = 3. Fetch of 32'h00000004 and of 32'h00000100 → NOP.
- Assert `rst_n` low after 3 bytes, release, load 4 bytes 13 00 00 00 and pulse `load_done` → `last_pc` = 0, `mem[0]` = 32'h00000013, no trace of the earlier bytes.
- In RUN, pulse `reload` → `run` = 0, `load_ready` = 1, `last_pc` = 32'hFFFFFFFF and `instr_data` = NOP on the next cycle. Load 1 new word and pulse `load_done` → `last_pc` = 0 and the new word is fetched at addr 0.
